// File: rtl/lut_table_seq.sv
// Write sequencer between the CSR block and the LUT table: merges single CSR entry writes
// with a bulk-fill engine, one table write per clock. Optional fill abort: LUT_TABLE_SEQ_ABORT_EN.
module lut_table_seq #(
  parameter int PX_WIDTH       = 10,
  parameter int CSR_FIFO_DEPTH = 4
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic [PX_WIDTH-1:0] csr_orig_px_i,
  input  logic [PX_WIDTH-1:0] csr_mod_px_i,
  input  logic                csr_wr_stb_i,
  input  logic                fill_start_i,
  input  logic [1:0]          fill_mode_i,
  input  logic [PX_WIDTH-1:0] fill_val_i,
  input  logic                ovf_clr_i,
  input  logic                abort_i,
  output logic [PX_WIDTH-1:0] lut_orig_px_o,
  output logic [PX_WIDTH-1:0] lut_mod_px_o,
  output logic                lut_wr_stb_o,
  output logic                busy_o,
  output logic                fill_done_o,
  output logic                csr_ovf_o,
  output logic                dbg_state_o
);

  localparam int AW = (CSR_FIFO_DEPTH > 1) ? $clog2(CSR_FIFO_DEPTH) : 1;
  localparam logic [AW:0]         CNT_FULL = (AW + 1)'(CSR_FIFO_DEPTH);
  localparam logic [PX_WIDTH-1:0] IDX_MAX  = '1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_FILL = 1'b1;

  localparam logic [1:0] MODE_INVERT = 2'd1;
  localparam logic [1:0] MODE_CONST  = 2'd2;

  logic [0:0]            r_state;
  logic [2*PX_WIDTH-1:0] r_fifo_mem [CSR_FIFO_DEPTH];
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [AW:0]           r_count;
  logic [PX_WIDTH-1:0]   r_idx;
  logic [1:0]            r_fill_mode;
  logic [PX_WIDTH-1:0]   r_fill_val;
  logic                  r_wr_stb;
  logic [PX_WIDTH-1:0]   r_wr_orig;
  logic [PX_WIDTH-1:0]   r_wr_mod;
  logic                  r_last_wr;
  logic                  r_done;
  logic                  r_busy;
  logic                  r_ovf;

  logic [0:0]            w_state_nxt;
  logic                  w_abort;
  logic                  w_fifo_empty;
  logic                  w_fifo_full;
  logic                  w_fill_go;
  logic                  w_pop;
  logic                  w_bypass;
  logic                  w_pop_fifo;
  logic                  w_push;
  logic                  w_drop;
  logic                  w_fill_wr;
  logic                  w_fill_last;
  logic [AW:0]           w_count_nxt;
  logic [PX_WIDTH-1:0]   w_idx_nxt;
  logic [PX_WIDTH-1:0]   w_fill_mod;
  logic [2*PX_WIDTH-1:0] w_fifo_rd;
  logic [2*PX_WIDTH-1:0] w_csr_entry;
  logic                  w_wr_stb_nxt;
  logic [PX_WIDTH-1:0]   w_wr_orig_nxt;
  logic [PX_WIDTH-1:0]   w_wr_mod_nxt;
  logic                  w_busy_nxt;

`ifdef LUT_TABLE_SEQ_ABORT_EN
  assign w_abort = abort_i && (r_state == ST_FILL);
`else
  // Port kept for a uniform interface; a fill always runs to completion.
  assign w_abort = abort_i & 1'b0;
`endif

  assign w_fifo_empty = (r_count == '0);
  assign w_fifo_full  = (r_count == CNT_FULL);
  assign w_fifo_rd    = r_fifo_mem[r_rd_ptr];
  assign w_csr_entry  = {csr_orig_px_i, csr_mod_px_i};

  // A strobe arriving on an empty FIFO in IDLE goes straight to the output register,
  // so the table write lands on the next cycle. Pops pause on the fill start cycle so a
  // strobe in that cycle is queued behind the fill.
  assign w_fill_go  = (r_state == ST_IDLE) && fill_start_i;
  assign w_pop      = (r_state == ST_IDLE) && !fill_start_i && (!w_fifo_empty || csr_wr_stb_i);
  assign w_bypass   = w_pop && w_fifo_empty;
  assign w_pop_fifo = w_pop && !w_fifo_empty;
  assign w_push     = csr_wr_stb_i && !w_bypass && (!w_fifo_full || w_pop);
  assign w_drop     = csr_wr_stb_i && w_fifo_full && !w_pop;

  assign w_fill_wr   = (r_state == ST_FILL) && !w_abort;
  assign w_fill_last = w_fill_wr && (r_idx == IDX_MAX);

  assign w_count_nxt = r_count + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop_fifo};

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_fill_go) w_state_nxt = ST_FILL;
      ST_FILL: if (w_abort || w_fill_last) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Index wraps to zero naturally after the last entry and is cleared on abort.
  always_comb begin
    w_idx_nxt = r_idx;
    if (r_state == ST_FILL) begin
      if (w_abort) w_idx_nxt = '0;
      else         w_idx_nxt = r_idx + 1'b1;
    end
  end

  always_comb begin
    w_fill_mod = r_idx;
    case (r_fill_mode)
      MODE_INVERT: w_fill_mod = ~r_idx;
      MODE_CONST:  w_fill_mod = r_fill_val;
      default:     w_fill_mod = r_idx;
    endcase
  end

  always_comb begin
    w_wr_stb_nxt  = 1'b0;
    w_wr_orig_nxt = '0;
    w_wr_mod_nxt  = '0;
    if (w_fill_wr) begin
      w_wr_stb_nxt  = 1'b1;
      w_wr_orig_nxt = r_idx;
      w_wr_mod_nxt  = w_fill_mod;
    end else if (w_pop) begin
      w_wr_stb_nxt = 1'b1;
      if (w_bypass) {w_wr_orig_nxt, w_wr_mod_nxt} = w_csr_entry;
      else          {w_wr_orig_nxt, w_wr_mod_nxt} = w_fifo_rd;
    end
  end

  // Busy also covers the cycle in which a bypassed write is on the output.
  assign w_busy_nxt = (w_state_nxt != ST_IDLE) || (w_count_nxt != '0) || w_wr_stb_nxt;

  always_ff @(posedge clk_i) begin
    if (w_push) r_fifo_mem[r_wr_ptr] <= w_csr_entry;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state     <= ST_IDLE;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_idx       <= '0;
      r_fill_mode <= '0;
      r_fill_val  <= '0;
      r_wr_stb    <= 1'b0;
      r_wr_orig   <= '0;
      r_wr_mod    <= '0;
      r_last_wr   <= 1'b0;
      r_done      <= 1'b0;
      r_busy      <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_count   <= w_count_nxt;
      r_idx     <= w_idx_nxt;
      if (w_push)     r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_fifo) r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_fill_go) begin
        r_fill_mode <= fill_mode_i;
        r_fill_val  <= fill_val_i;
      end
      r_wr_stb  <= w_wr_stb_nxt;
      r_wr_orig <= w_wr_orig_nxt;
      r_wr_mod  <= w_wr_mod_nxt;
      r_last_wr <= w_fill_last;
      r_done    <= r_last_wr;
      r_busy    <= w_busy_nxt;
      if (w_drop)         r_ovf <= 1'b1;
      else if (ovf_clr_i) r_ovf <= 1'b0;
    end
  end

  assign lut_orig_px_o = r_wr_orig;
  assign lut_mod_px_o  = r_wr_mod;
  assign lut_wr_stb_o  = r_wr_stb;
  assign busy_o        = r_busy;
  assign fill_done_o   = r_done;
  assign csr_ovf_o     = r_ovf;
  assign dbg_state_o   = r_state;

endmodule

// File: tb/tb_lut_table_seq.sv
// Bench for lut_table_seq: directed steps with random data, every table write is
// compared in order against a queue built from the behavioural rules.
module tb_lut_table_seq;
  localparam int PXW   = 8;
  localparam int DEPTH = 4;
  localparam int N     = 1 << PXW;
`ifdef LUT_TABLE_SEQ_ABORT_EN
  localparam int ABORT_EXP = 6;
`else
  localparam int ABORT_EXP = N;
`endif

  logic           clk_i = 1'b0;
  logic           rst_n_i;
  logic [PXW-1:0] csr_orig_px_i, csr_mod_px_i, fill_val_i;
  logic           csr_wr_stb_i, fill_start_i, ovf_clr_i, abort_i;
  logic [1:0]     fill_mode_i;
  logic [PXW-1:0] lut_orig_px_o, lut_mod_px_o;
  logic           lut_wr_stb_o, busy_o, fill_done_o, csr_ovf_o, dbg_state;

  lut_table_seq #(.PX_WIDTH(PXW), .CSR_FIFO_DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .csr_orig_px_i(csr_orig_px_i), .csr_mod_px_i(csr_mod_px_i), .csr_wr_stb_i(csr_wr_stb_i),
    .fill_start_i(fill_start_i), .fill_mode_i(fill_mode_i), .fill_val_i(fill_val_i),
    .ovf_clr_i(ovf_clr_i), .abort_i(abort_i),
    .lut_orig_px_o(lut_orig_px_o), .lut_mod_px_o(lut_mod_px_o), .lut_wr_stb_o(lut_wr_stb_o),
    .busy_o(busy_o), .fill_done_o(fill_done_o), .csr_ovf_o(csr_ovf_o), .dbg_state_o(dbg_state)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int wr_count = 0;
  int done_count = 0;
  logic [2*PXW-1:0] exp_q[$];
  logic           prev_stb = 1'b0;
  logic [PXW-1:0] prev_orig = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every write must match the head of the expected queue.
  always @(negedge clk_i) begin
    if (rst_n_i) begin
      if (lut_wr_stb_o) begin
        wr_count++;
        check("sb_unexpected_wr", 32'(exp_q.size() == 0), 0);
        if (exp_q.size() != 0) check("sb_wr_data", {lut_orig_px_o, lut_mod_px_o}, exp_q.pop_front());
      end
      if (fill_done_o) begin
        done_count++;
        check("done_after_last", {prev_stb, prev_orig}, {1'b1, PXW'(N - 1)});
      end
      prev_stb  = lut_wr_stb_o;
      prev_orig = lut_orig_px_o;
    end
  end

  function automatic logic [2*PXW-1:0] fill_exp(input int mode, input int val, input int k);
    int m;
    if (mode == 1)      m = N - 1 - k;
    else if (mode == 2) m = val;
    else                m = k;
    return {PXW'(k), PXW'(m)};
  endfunction

  task automatic step();
    @(negedge clk_i);
    #1;
  endtask

  task automatic csr_wr(input int orig, input int mod, input bit expect_wr);
    csr_orig_px_i = PXW'(orig);
    csr_mod_px_i  = PXW'(mod);
    csr_wr_stb_i  = 1'b1;
    if (expect_wr) exp_q.push_back({PXW'(orig), PXW'(mod)});
    step();
    csr_wr_stb_i  = 1'b0;
  endtask

  task automatic fill_start(input int mode, input int val, input int n_exp, input bit csr_same);
    for (int k = 0; k < n_exp; k++) exp_q.push_back(fill_exp(mode, val, k));
    fill_mode_i  = 2'(mode);
    fill_val_i   = PXW'(val);
    fill_start_i = 1'b1;
    if (csr_same) begin
      csr_orig_px_i = PXW'(8'hA5);
      csr_mod_px_i  = PXW'(8'h3C);
      csr_wr_stb_i  = 1'b1;
      exp_q.push_back({PXW'(8'hA5), PXW'(8'h3C)});
    end
    step();
    fill_start_i = 1'b0;
    csr_wr_stb_i = 1'b0;
    fill_mode_i  = 2'($urandom_range(0, 3));
    fill_val_i   = PXW'($urandom_range(0, N - 1));
  endtask

  task automatic wait_done(input string tag, input int prev);
    for (int i = 0; i < 2 * N && done_count == prev; i++) step();
    check(tag, done_count, prev + 1);
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 3 * N && (exp_q.size() != 0 || busy_o); i++) step();
    check({tag, "_drained"}, exp_q.size(), 0);
    check({tag, "_idle"}, {busy_o, dbg_state}, 0);
  endtask

  initial begin
    int d0, w0;
    rst_n_i = 1'b0; csr_wr_stb_i = 1'b0; fill_start_i = 1'b0; ovf_clr_i = 1'b0; abort_i = 1'b0;
    csr_orig_px_i = '0; csr_mod_px_i = '0; fill_mode_i = '0; fill_val_i = '0;
    repeat (3) step();
    check("reset_outputs", {lut_orig_px_o, lut_mod_px_o, lut_wr_stb_o, busy_o, fill_done_o, csr_ovf_o, dbg_state}, 0);
    rst_n_i = 1'b1;
    step();

    // Single CSR write: table write on the next cycle, busy for exactly that cycle.
    csr_wr(5, 200, 1'b1);
    check("t1_wr_next_cycle", {lut_wr_stb_o, busy_o}, 2'b11);
    step();
    check("t1_quiet_after", {lut_wr_stb_o, busy_o}, 2'b00);
    check("t1_wr_total", wr_count, 1);

    // Random idle CSR traffic drains at one per cycle without overflow.
    for (int i = 0; i < 20; i++) begin
      csr_wr($urandom_range(0, N - 1), $urandom_range(0, N - 1), 1'b1);
      repeat ($urandom_range(0, 2)) step();
    end
    wait_drain("rand_csr");
    check("rand_csr_no_ovf", csr_ovf_o, 0);

    // Inverted fill.
    d0 = done_count;
    fill_start(1, $urandom_range(0, N - 1), N, 1'b0);
    check("fill1_state", {dbg_state, busy_o}, 2'b11);
    wait_done("fill1_done", d0);
    wait_drain("fill1");

    // Constant fill with three CSR writes and an ignored restart mid-fill.
    d0 = done_count;
    fill_start(2, 7, N, 1'b0);
    for (int i = 0; i < 3; i++) begin
      repeat ($urandom_range(5, 40)) step();
      csr_wr($urandom_range(0, N - 1), $urandom_range(0, N - 1), 1'b1);
    end
    fill_start_i = 1'b1; fill_mode_i = 2'd0;
    step();
    fill_start_i = 1'b0;
    wait_done("fill2_done", d0);
    wait_drain("fill2");
    check("fill2_single_done", done_count, d0 + 1);

    // Overflow: five strobes into a four-deep FIFO, set wins over clear.
    d0 = done_count;
    fill_start(2, $urandom_range(0, N - 1), N, 1'b0);
    repeat (5) step();
    for (int i = 0; i < 5; i++) csr_wr(16 + i, 100 + i, i < DEPTH);
    check("ovf_set", csr_ovf_o, 1);
    ovf_clr_i = 1'b1;
    csr_wr(99, 99, 1'b0);
    ovf_clr_i = 1'b0;
    check("ovf_set_beats_clr", csr_ovf_o, 1);
    wait_done("ovf_fill_done", d0);
    wait_drain("ovf");
    check("ovf_sticky", csr_ovf_o, 1);
    ovf_clr_i = 1'b1;
    step();
    ovf_clr_i = 1'b0;
    check("ovf_cleared", csr_ovf_o, 0);

    // Random fills in every mode, some with a CSR strobe on the start cycle.
    for (int m = 0; m < 4; m++) begin
      d0 = done_count;
      fill_start(m, $urandom_range(0, N - 1), N, m[0]);
      for (int i = 0; i < int'($urandom_range(0, 3)); i++) begin
        repeat ($urandom_range(3, 50)) step();
        csr_wr($urandom_range(0, N - 1), $urandom_range(0, N - 1), 1'b1);
      end
      wait_done("rand_fill_done", d0);
      wait_drain("rand_fill");
    end

    // Abort at index 6 (ignored unless the abort feature is built in).
    d0 = done_count;
    fill_start(0, 0, ABORT_EXP, 1'b0);
    csr_wr(33, 44, 1'b1);
    repeat (5) step();
    abort_i = 1'b1;
    step();
    abort_i = 1'b0;
    wait_drain("abort");
    repeat (4) step();
    check("abort_done_count", done_count, d0 + ((ABORT_EXP == N) ? 1 : 0));

    // Reset while the fill is at index 3: everything is abandoned.
    d0 = done_count;
    fill_start(1, 0, N, 1'b0);
    csr_wr(1, 2, 1'b0);
    step();
    step();
    #1 rst_n_i = 1'b0;
    exp_q.delete();
    #1;
    check("rst_mid_fill_outputs", {lut_wr_stb_o, busy_o, fill_done_o, csr_ovf_o, dbg_state, lut_orig_px_o, lut_mod_px_o}, 0);
    w0 = wr_count;
    repeat (2) step();
    rst_n_i = 1'b1;
    repeat (20) step();
    check("rst_no_writes_after", wr_count, w0);
    check("rst_no_done", done_count, d0);
    check("rst_idle", {busy_o, dbg_state}, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
